// File: rtl/dice_cfg_pkg.sv
// Shared types and constants for the DICE static-configuration loader.
// The optional trailer checksum is enabled by defining DICE_CFG_CHECKSUM_EN.
package dice_cfg_pkg;

  localparam int DICE_TILE_CFG_W = 156;
  localparam int DICE_CFG_WORDS  = 5;

  localparam int HDR_START_MSB = 31;
  localparam int HDR_START_LSB = 16;
  localparam int HDR_COUNT_MSB = 15;
  localparam int HDR_COUNT_LSB = 0;

  typedef logic [DICE_TILE_CFG_W-1:0] tile_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHK,
    DONE
  } cfg_ld_state_e;

  // start+count is summed in 17 bits so a header near 0xFFFF cannot wrap into range.
  function automatic logic hdr_bad(input logic [31:0] hdr, input int unsigned n_tiles);
    logic [16:0] span;
    span = {1'b0, hdr[HDR_START_MSB:HDR_START_LSB]} + {1'b0, hdr[HDR_COUNT_MSB:HDR_COUNT_LSB]};
    return (hdr[HDR_COUNT_MSB:HDR_COUNT_LSB] == '0) || (span > 17'(n_tiles));
  endfunction

endpackage

// File: rtl/dice_cfg_word_asm.sv
// Shadow register and word counter: packs five 32-bit stream words into one
// 156-bit tile configuration and strobes commit_o as the last word arrives.
module dice_cfg_word_asm
  import dice_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        word_valid_i,
  input  logic [31:0] word_i,
  output tile_cfg_t   cfg_o,
  output logic        commit_o
);

  localparam logic [2:0] LAST_WORD = 3'(DICE_CFG_WORDS - 1);

  tile_cfg_t  shadow_q, shadow_d;
  logic [2:0] word_cnt_q, word_cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shadow_d   = shadow_q;
    word_cnt_d = word_cnt_q;
    if (clear_i) begin
      shadow_d   = '0;
      word_cnt_d = '0;
    end else if (word_valid_i) begin
      for (int k = 0; k < DICE_CFG_WORDS - 1; k++) begin
        if (word_cnt_q == 3'(k)) shadow_d[k*32 +: 32] = word_i;
      end
      // The last word only carries 28 payload bits; its top nibble is dropped.
      if (word_cnt_q == LAST_WORD) shadow_d[DICE_TILE_CFG_W-1:128] = word_i[27:0];
      word_cnt_d = (word_cnt_q == LAST_WORD) ? 3'd0 : word_cnt_q + 3'd1;
    end
  end

  // The merged value includes the word being accepted, so the tile register
  // can take it on the same edge as the final handshake.
  assign cfg_o    = shadow_d;
  assign commit_o = word_valid_i && !clear_i && (word_cnt_q == LAST_WORD);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      shadow_q   <= '0;
      word_cnt_q <= '0;
    end else begin
      shadow_q   <= shadow_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: rtl/dice_cfg_loader.sv
// DICE CGRA static-configuration loader: header + per-tile payload stream into
// atomically committed tile cfg registers. Define DICE_CFG_CHECKSUM_EN for the XOR trailer.
module dice_cfg_loader
  import dice_cfg_pkg::*;
#(
  parameter int N_TILES = 16,
  parameter int CFG_W   = DICE_TILE_CFG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              cfg_in_data,
  input  logic                     cfg_in_valid,
  output logic                     cfg_in_ready,
  input  logic                     cfg_abort,
  output logic [N_TILES*CFG_W-1:0] tile_cfg_o,
  output logic                     cgra_hold,
  output logic                     cfg_done,
  output logic                     cfg_err
);

`ifdef DICE_CFG_CHECKSUM_EN
  localparam cfg_ld_state_e AFTER_LAST = CHK;
  logic [31:0] xor_q, xor_d;
`else
  localparam cfg_ld_state_e AFTER_LAST = DONE;
`endif

  cfg_ld_state_e state_q, state_d;
  logic [15:0]   tile_ptr_q, tile_ptr_d;
  logic [15:0]   remaining_q, remaining_d;
  logic          err_q, err_d;
  logic          fire, asm_valid, asm_clear, commit;
  tile_cfg_t     asm_cfg;
  tile_cfg_t     tile_cfg_q [N_TILES];

  // Abort wins over a same-cycle word in every state, including a header in IDLE.
  assign cfg_in_ready = !rst && (state_q != DONE);
  assign fire         = cfg_in_valid && cfg_in_ready && !cfg_abort;
  assign asm_valid    = fire && (state_q == LOAD);
  assign asm_clear    = cfg_abort && (state_q != IDLE);
  assign cgra_hold    = (state_q == LOAD) || (state_q == CHK);
  assign cfg_done     = (state_q == DONE);
  assign cfg_err      = err_q;

  dice_cfg_word_asm u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (asm_clear),
    .word_valid_i (asm_valid),
    .word_i       (cfg_in_data),
    .cfg_o        (asm_cfg),
    .commit_o     (commit)
  );

  always_comb begin
    state_d     = state_q;
    tile_ptr_d  = tile_ptr_q;
    remaining_d = remaining_q;
    err_d       = 1'b0;
`ifdef DICE_CFG_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (hdr_bad(cfg_in_data, N_TILES)) begin
            err_d = 1'b1;
          end else begin
            tile_ptr_d  = cfg_in_data[HDR_START_MSB:HDR_START_LSB];
            remaining_d = cfg_in_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
            state_d     = LOAD;
`ifdef DICE_CFG_CHECKSUM_EN
            xor_d       = cfg_in_data;
`endif
          end
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (fire) begin
`ifdef DICE_CFG_CHECKSUM_EN
          xor_d = xor_q ^ cfg_in_data;
`endif
          if (commit) begin
            tile_ptr_d  = tile_ptr_q + 16'd1;
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) state_d = AFTER_LAST;
          end
        end
      end
`ifdef DICE_CFG_CHECKSUM_EN
      CHK: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (fire) begin
          err_d   = (cfg_in_data != xor_q);
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tile_ptr_q  <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
`ifdef DICE_CFG_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tile_ptr_q  <= tile_ptr_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
`ifdef DICE_CFG_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  // NOTE: the tile array is reset deliberately: the fabric must see a known all-zero cfg out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TILES; i++) tile_cfg_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < N_TILES; i++) begin
        if (tile_ptr_q == 16'(i)) tile_cfg_q[i] <= asm_cfg;
      end
    end
  end

  for (genvar g = 0; g < N_TILES; g++) begin : g_tile_out
    assign tile_cfg_o[g*CFG_W +: CFG_W] = tile_cfg_q[g];
  end

endmodule

// File: tb/tb_dice_cfg_loader.sv
// Self-checking bench for dice_cfg_loader: directed loads, bad headers, aborts and
// randomized loads against a per-tile reference array; honours DICE_CFG_CHECKSUM_EN.
module tb_dice_cfg_loader;
  import dice_cfg_pkg::*;

  localparam int NT = 16;
  localparam int CW = 156;
`ifdef DICE_CFG_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [31:0]    cfg_in_data;
  logic           cfg_in_valid;
  logic           cfg_in_ready;
  logic           cfg_abort;
  logic [NT*CW-1:0] tile_cfg_o;
  logic           cgra_hold;
  logic           cfg_done;
  logic           cfg_err;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;

  logic [CW-1:0] model [NT];

  dice_cfg_loader #(.N_TILES(NT), .CFG_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_in_data  (cfg_in_data),
    .cfg_in_valid (cfg_in_valid),
    .cfg_in_ready (cfg_in_ready),
    .cfg_abort    (cfg_abort),
    .tile_cfg_o   (tile_cfg_o),
    .cgra_hold    (cgra_hold),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled with the pre-edge value of each cycle.
  always @(posedge clk) begin
    if (!rst) begin
      if (cfg_done === 1'b1) done_cnt++;
      if (cfg_err === 1'b1) err_cnt++;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] tile_slice(input int i);
    return tile_cfg_o[i*CW +: CW];
  endfunction

  task automatic check_bus(input string tag);
    for (int i = 0; i < NT; i++) check($sformatf("%s_tile%0d", tag, i), tile_slice(i), model[i]);
  endtask

  // Returns on the falling edge one cycle after the handshake.
  task automatic send_word(input logic [31:0] w, input int gap);
    int budget;
    cfg_in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    cfg_in_data  = w;
    cfg_in_valid = 1'b1;
    budget = 0;
    while (cfg_in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("ready", cfg_in_ready, 1'b1);
    @(negedge clk);
    cfg_in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] start, input logic [15:0] cnt, input bit corrupt);
    logic [31:0] w [5];
    logic [31:0] sum;
    int d0, e0, idx;
    bit last, exp_err;
    d0 = done_cnt;
    e0 = err_cnt;
    exp_err = corrupt && CSUM;
    sum = {start, cnt};
    send_word({start, cnt}, int'($urandom_range(0, 2)));
    check("hold_after_hdr", cgra_hold, 1'b1);
    for (int t = 0; t < int'(cnt); t++) begin
      for (int k = 0; k < 5; k++) begin
        w[k] = $urandom;
        sum ^= w[k];
        send_word(w[k], int'($urandom_range(0, 3)));
        last = (t == int'(cnt) - 1) && (k == 4);
        if (k == 4) begin
          idx = int'(start) + t;
          model[idx] = {w[4][27:0], w[3], w[2], w[1], w[0]};
          check_bus("commit");
        end
`ifdef DICE_CFG_CHECKSUM_EN
        check("hold_load", cgra_hold, 1'b1);
        check("done_early", cfg_done, 1'b0);
`else
        check("hold_load", cgra_hold, !last);
        check("done_at_last", cfg_done, last);
`endif
      end
    end
`ifdef DICE_CFG_CHECKSUM_EN
    send_word(sum ^ {31'd0, corrupt}, int'($urandom_range(0, 3)));
    check("done_after_sum", cfg_done, 1'b1);
    check("err_after_sum", cfg_err, corrupt);
    check("hold_after_sum", cgra_hold, 1'b0);
`endif
    @(negedge clk);
    check("done_clear", cfg_done, 1'b0);
    check("err_clear", cfg_err, 1'b0);
    check("ready_idle", cfg_in_ready, 1'b1);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("err_count", 32'(err_cnt - e0), {31'd0, exp_err});
    check_bus("post_load");
  endtask

  task automatic bad_header(input logic [31:0] hdr);
    int e0, d0;
    e0 = err_cnt;
    d0 = done_cnt;
    send_word(hdr, 0);
    check("bad_err", cfg_err, 1'b1);
    check("bad_hold", cgra_hold, 1'b0);
    check("bad_ready", cfg_in_ready, 1'b1);
    @(negedge clk);
    check("bad_err_clear", cfg_err, 1'b0);
    check("bad_err_count", 32'(err_cnt - e0), 32'd1);
    check("bad_done_count", 32'(done_cnt - d0), 32'd0);
    check_bus("bad_hdr");
  endtask

  initial begin
    logic [31:0] words [5];
    logic [31:0] sum;
    logic [15:0] rs, rc;
    int d0, e0;

    for (int i = 0; i < NT; i++) model[i] = '0;
    rst = 1'b1;
    cfg_in_data = '0;
    cfg_in_valid = 1'b0;
    cfg_abort = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", cfg_in_ready, 1'b0);
    check("rst_hold", cgra_hold, 1'b0);
    check("rst_done", cfg_done, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    check_bus("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", cfg_in_ready, 1'b1);
    check("idle_hold", cgra_hold, 1'b0);
    check("idle_done", cfg_done, 1'b0);
    check("idle_err", cfg_err, 1'b0);

    // Directed single-tile load into tile 3
    words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'hF555_5555};
    d0 = done_cnt;
    sum = 32'h0003_0001;
    send_word(32'h0003_0001, 0);
    check("t3_hold", cgra_hold, 1'b1);
    for (int k = 0; k < 5; k++) begin
      sum ^= words[k];
      send_word(words[k], 0);
    end
    model[3] = 156'h5555555_44444444_33333333_22222222_11111111;
    check("t3_cfg", tile_slice(3), 156'h5555555_44444444_33333333_22222222_11111111);
    check("t3_top_field", tile_cfg_o[3*CW+128 +: 28], 28'h5555555);
    check_bus("t3");
`ifdef DICE_CFG_CHECKSUM_EN
    check("t3_no_done_yet", cfg_done, 1'b0);
    send_word(sum, 0);
`endif
    check("t3_done", cfg_done, 1'b1);
    check("t3_hold_drop", cgra_hold, 1'b0);
    check("t3_err", cfg_err, 1'b0);
    @(negedge clk);
    check("t3_done_clear", cfg_done, 1'b0);
    check("t3_done_count", 32'(done_cnt - d0), 32'd1);

    // Two tiles at the top of the array with random gaps
    do_load(16'd14, 16'd2, 1'b0);

    // Bad headers, including one that would wrap in 16 bits
    bad_header(32'h000F_0002);
    bad_header(32'h0000_0000);
    bad_header(32'hFFFF_0002);
    rs = 16'($urandom_range(0, 15));
    bad_header({rs, 16'(NT) - rs + 16'($urandom_range(1, 40))});

    // Abort on the third word of tile 1 in a two-tile load
    d0 = done_cnt;
    e0 = err_cnt;
    send_word(32'h0000_0002, 0);
    for (int k = 0; k < 5; k++) begin
      words[k] = $urandom;
      send_word(words[k], int'($urandom_range(0, 2)));
    end
    model[0] = {words[4][27:0], words[3], words[2], words[1], words[0]};
    for (int k = 0; k < 2; k++) send_word($urandom, 0);
    cfg_in_data = $urandom;
    cfg_in_valid = 1'b1;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_in_valid = 1'b0;
    cfg_abort = 1'b0;
    check("abort_hold", cgra_hold, 1'b0);
    check("abort_ready", cfg_in_ready, 1'b1);
    check("abort_done", cfg_done, 1'b0);
    check("abort_err", cfg_err, 1'b0);
    check_bus("abort");
    @(negedge clk);
    check("abort_done_count", 32'(done_cnt - d0), 32'd0);
    check("abort_err_count", 32'(err_cnt - e0), 32'd0);

    // Abort in IDLE drops a same-cycle header
    cfg_in_data = 32'h0000_0001;
    cfg_in_valid = 1'b1;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_in_valid = 1'b0;
    cfg_abort = 1'b0;
    check("idle_abort_hold", cgra_hold, 1'b0);
    check("idle_abort_err", cfg_err, 1'b0);

    // Boundary and randomized loads
    do_load(16'd15, 16'd1, 1'b0);
    do_load(16'd0, 16'd16, 1'b0);
    for (int n = 0; n < 6; n++) begin
      rs = 16'($urandom_range(0, 15));
      rc = 16'($urandom_range(1, 16 - int'(rs)));
      do_load(rs, rc, 1'b0);
    end

`ifdef DICE_CFG_CHECKSUM_EN
    // Checksum trailer: correct, then off by one bit
    do_load(16'd5, 16'd1, 1'b0);
    do_load(16'd6, 16'd1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
